// File: rtl/interposer_pkg.sv
// Shared definitions for the interposer segment arbiter: NodeIO control encodings,
// arbiter FSM states and request field layout.
package interposer_pkg;

    localparam logic [2:0] CTRL_IDLE   = 3'b000;
    localparam logic [2:0] CTRL_TX     = 3'b100;
    localparam logic [2:0] CTRL_RX     = 3'b010;
    localparam logic [2:0] CTRL_BYPASS = 3'b001;

    typedef enum logic [1:0] {StIdle, StTx, StHop, StRx} arb_state_t;

    // A request slice is {valid, dest}; dest sits at the bottom.
    localparam int unsigned REQ_DEST_LSB = 0;

    function automatic int unsigned req_valid_bit(input int unsigned dest_width);
        return dest_width;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of legal, searching cyclically
// upward from rr_ptr.
module rr_picker #(
    parameter int unsigned NODE_COUNT       = 8,
    parameter int unsigned NODE_COUNT_DIGIT = 3
) (
    input  logic [NODE_COUNT-1:0]       legal,
    input  logic [NODE_COUNT_DIGIT-1:0] rr_ptr,
    output logic                        found,
    output logic [NODE_COUNT_DIGIT-1:0] winner
);

    int unsigned idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NODE_COUNT; k++) begin
            idx = (32'(rr_ptr) + k) % NODE_COUNT;
            if (!found && legal[idx[NODE_COUNT_DIGIT-1:0]]) begin
                found  = 1'b1;
                winner = idx[NODE_COUNT_DIGIT-1:0];
            end
        end
    end

endmodule

// File: rtl/segment_arbiter.sv
// Per-direction segment arbiter: grants one NodeIO source per transfer and sequences
// Tx / bypass / Rx controls. Optional counters under SEGMENT_ARBITER_STATS_EN.
module segment_arbiter
    import interposer_pkg::*;
#(
    parameter int unsigned DIRECTION          = 0,
    parameter int unsigned NODE_COUNT         = 8,
    parameter int unsigned NODE_COUNT_DIGIT   = 3,
    parameter int unsigned ARBITER_SIGNAL_IN  = 3,
    parameter int unsigned ARBITER_SIGNAL_OUT = NODE_COUNT_DIGIT + 1,
    parameter int unsigned STAT_WIDTH         = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NODE_COUNT*ARBITER_SIGNAL_OUT-1:0]   request_in,
    output logic [NODE_COUNT*ARBITER_SIGNAL_IN-1:0]    control_out,
    output logic                                       busy,
    output logic [NODE_COUNT_DIGIT-1:0]                grant_src,
    output logic [NODE_COUNT_DIGIT-1:0]                grant_dst,
    output logic [NODE_COUNT-1:0]                      illegal_req
`ifdef SEGMENT_ARBITER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]                      xfer_count,
    output logic [STAT_WIDTH-1:0]                      illegal_count
`endif
);

    localparam int unsigned REQ_W     = ARBITER_SIGNAL_OUT;
    localparam int unsigned CTRL_W    = ARBITER_SIGNAL_IN;
    localparam int unsigned VALID_BIT = req_valid_bit(NODE_COUNT_DIGIT);
    localparam logic [NODE_COUNT_DIGIT-1:0] ADDR_ONE  = NODE_COUNT_DIGIT'(1);
    localparam logic [NODE_COUNT_DIGIT-1:0] ADDR_LAST = NODE_COUNT_DIGIT'(NODE_COUNT - 1);

    arb_state_t                         state_q, state_d;
    logic [NODE_COUNT_DIGIT-1:0]        src_q, src_d, dst_q, dst_d;
    logic [NODE_COUNT_DIGIT-1:0]        cnt_q, cnt_d, ptr_q, ptr_d, hop;
    logic [NODE_COUNT*CTRL_W-1:0]       control_q, control_d;
    logic                               busy_q;
    logic [NODE_COUNT-1:0]              illegal_q;

    logic [NODE_COUNT_DIGIT-1:0]        req_dest [NODE_COUNT];
    logic [NODE_COUNT-1:0]              req_valid, dir_ok, legal, illegal;
    logic                               pick_found;
    logic [NODE_COUNT_DIGIT-1:0]        pick_winner;
    int unsigned                        src_idx, dst_idx;

    always_comb begin
        req_valid = '0;
        dir_ok    = '0;
        for (int unsigned i = 0; i < NODE_COUNT; i++) begin
            req_dest[i]  = request_in[i*REQ_W + REQ_DEST_LSB +: NODE_COUNT_DIGIT];
            req_valid[i] = request_in[i*REQ_W + VALID_BIT];
            if (DIRECTION == 0) begin
                dir_ok[i] = (32'(req_dest[i]) > i) && (32'(req_dest[i]) < NODE_COUNT);
            end else begin
                dir_ok[i] = 32'(req_dest[i]) < i;
            end
        end
        legal   = req_valid & dir_ok;
        illegal = req_valid & ~dir_ok;
    end

    rr_picker #(
        .NODE_COUNT       (NODE_COUNT),
        .NODE_COUNT_DIGIT (NODE_COUNT_DIGIT)
    ) u_rr_picker (
        .legal  (legal),
        .rr_ptr (ptr_q),
        .found  (pick_found),
        .winner (pick_winner)
    );

    assign hop = (DIRECTION == 0) ? (dst_q - src_q) : (src_q - dst_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    src_d   = pick_winner;
                    dst_d   = req_dest[pick_winner];
                    ptr_d   = (pick_winner == ADDR_LAST) ? '0 : pick_winner + ADDR_ONE;
                    state_d = StTx;
                end
            end
            StTx: begin
                if (hop == ADDR_ONE) begin
                    state_d = StRx;
                end else begin
                    state_d = StHop;
                    cnt_d   = hop - ADDR_ONE;
                end
            end
            StHop: begin
                cnt_d = cnt_q - ADDR_ONE;
                if (cnt_q == ADDR_ONE) begin
                    state_d = StRx;
                end
            end
            StRx:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Controls are derived from the next state so they are registered alongside it.
    always_comb begin
        control_d = '0;
        src_idx   = 32'(src_d);
        dst_idx   = 32'(dst_d);
        for (int unsigned i = 0; i < NODE_COUNT; i++) begin
            case (state_d)
                StTx: if (i == src_idx) control_d[i*CTRL_W +: CTRL_W] = CTRL_TX;
                StHop: begin
                    if ((DIRECTION == 0) ? (i > src_idx && i < dst_idx)
                                         : (i < src_idx && i > dst_idx)) begin
                        control_d[i*CTRL_W +: CTRL_W] = CTRL_BYPASS;
                    end
                end
                StRx: if (i == dst_idx) control_d[i*CTRL_W +: CTRL_W] = CTRL_RX;
                default: control_d[i*CTRL_W +: CTRL_W] = CTRL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            control_q <= '0;
            busy_q    <= 1'b0;
            illegal_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            control_q <= control_d;
            busy_q    <= (state_d != StIdle);
            if (state_q == StIdle) begin
                illegal_q <= illegal;
            end
        end
    end

    assign control_out = control_q;
    assign busy        = busy_q;
    assign grant_src   = src_q;
    assign grant_dst   = dst_q;
    assign illegal_req = illegal_q;

`ifdef SEGMENT_ARBITER_STATS_EN
    logic [STAT_WIDTH-1:0] xfer_q, ill_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            xfer_q    <= '0;
            ill_cnt_q <= '0;
        end else begin
            if (state_q == StTx && xfer_q != '1) begin
                xfer_q <= xfer_q + STAT_WIDTH'(1);
            end
            if (state_q == StIdle && |illegal && ill_cnt_q != '1) begin
                ill_cnt_q <= ill_cnt_q + STAT_WIDTH'(1);
            end
        end
    end

    assign xfer_count    = xfer_q;
    assign illegal_count = ill_cnt_q;
`else
    // STAT_WIDTH only sizes the stats counters, which are absent in this build.
    if (STAT_WIDTH == 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_segment_arbiter.sv
// Directed bench for segment_arbiter: one low-to-high and one high-to-low instance.
module tb_segment_arbiter;

    localparam int N  = 8;
    localparam int D  = 3;
    localparam int CI = 3;
    localparam int RO = 4;

    logic            clk   = 1'b0;
    logic            reset = 1'b0;
    logic [N*RO-1:0] req0  = '0;
    logic [N*RO-1:0] req1  = '0;
    logic [N*CI-1:0] ctrl0, ctrl1;
    logic            busy0, busy1;
    logic [D-1:0]    src0, dst0, src1, dst1;
    logic [N-1:0]    ill0, ill1;
`ifdef SEGMENT_ARBITER_STATS_EN
    logic [15:0]     xc0, ic0, xc1, ic1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    segment_arbiter #(.DIRECTION(0), .NODE_COUNT(N), .NODE_COUNT_DIGIT(D)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .request_in  (req0),
        .control_out (ctrl0),
        .busy        (busy0),
        .grant_src   (src0),
        .grant_dst   (dst0),
        .illegal_req (ill0)
`ifdef SEGMENT_ARBITER_STATS_EN
        ,
        .xfer_count    (xc0),
        .illegal_count (ic0)
`endif
    );

    segment_arbiter #(.DIRECTION(1), .NODE_COUNT(N), .NODE_COUNT_DIGIT(D)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .request_in  (req1),
        .control_out (ctrl1),
        .busy        (busy1),
        .grant_src   (src1),
        .grant_dst   (dst1),
        .illegal_req (ill1)
`ifdef SEGMENT_ARBITER_STATS_EN
        ,
        .xfer_count    (xc1),
        .illegal_count (ic1)
`endif
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(2);
        checks += 6;
        if (ctrl0 !== '0) begin failures++; $display("FAIL reset_ctrl0 got=%o exp=0", ctrl0); end
        if (ctrl1 !== '0) begin failures++; $display("FAIL reset_ctrl1 got=%o exp=0", ctrl1); end
        if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        if (src0 !== 3'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", src0); end
        if (dst0 !== 3'd0) begin failures++; $display("FAIL reset_dst got=%0d exp=0", dst0); end
        if (ill0 !== 8'h00) begin failures++; $display("FAIL reset_illegal got=%b exp=0", ill0); end
        reset = 1'b1;
    endtask

    task automatic test_hop_2_to_5();
        logic [23:0] exp_c [5];
        logic        exp_b [5];
        exp_c = '{24'o00000400, 24'o00011000, 24'o00011000, 24'o00200000, 24'o00000000};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        req0[2*RO +: RO] = {1'b1, 3'd5};
        step(1);
        req0 = '0;
        checks += 2;
        if (src0 !== 3'd2) begin failures++; $display("FAIL hop25_src got=%0d exp=2", src0); end
        if (dst0 !== 3'd5) begin failures++; $display("FAIL hop25_dst got=%0d exp=5", dst0); end
        for (int k = 0; k < 5; k++) begin
            checks += 2;
            if (ctrl0 !== exp_c[k]) begin
                failures++;
                $display("FAIL hop25_ctrl cyc=%0d got=%o exp=%o", k, ctrl0, exp_c[k]);
            end
            if (busy0 !== exp_b[k]) begin
                failures++;
                $display("FAIL hop25_busy cyc=%0d got=%b exp=%b", k, busy0, exp_b[k]);
            end
            step(1);
        end
    endtask

    task automatic test_short_6_to_7();
        logic [23:0] exp_c [3];
        logic        exp_b [3];
        exp_c = '{24'o04000000, 24'o20000000, 24'o00000000};
        exp_b = '{1'b1, 1'b1, 1'b0};
        req0[6*RO +: RO] = {1'b1, 3'd7};
        step(1);
        req0 = '0;
        for (int k = 0; k < 3; k++) begin
            checks += 2;
            if (ctrl0 !== exp_c[k]) begin
                failures++;
                $display("FAIL short67_ctrl cyc=%0d got=%o exp=%o", k, ctrl0, exp_c[k]);
            end
            if (busy0 !== exp_b[k]) begin
                failures++;
                $display("FAIL short67_busy cyc=%0d got=%b exp=%b", k, busy0, exp_b[k]);
            end
            step(1);
        end
    endtask

    task automatic test_illegal_and_dir1();
        logic [23:0] exp_c [4];
        exp_c = '{24'o00400000, 24'o00010000, 24'o00002000, 24'o00000000};
        req0[5*RO +: RO] = {1'b1, 3'd3};
        req1[5*RO +: RO] = {1'b1, 3'd3};
        step(1);
        req1 = '0;
        checks += 4;
        if (ill0 !== 8'b0010_0000) begin failures++; $display("FAIL illegal_bit got=%b exp=00100000", ill0); end
        if (ill1 !== 8'b0000_0000) begin failures++; $display("FAIL dir1_illegal got=%b exp=0", ill1); end
        if (src1 !== 3'd5) begin failures++; $display("FAIL dir1_src got=%0d exp=5", src1); end
        if (dst1 !== 3'd3) begin failures++; $display("FAIL dir1_dst got=%0d exp=3", dst1); end
        for (int k = 0; k < 4; k++) begin
            checks += 2;
            if (ctrl1 !== exp_c[k]) begin
                failures++;
                $display("FAIL dir1_ctrl cyc=%0d got=%o exp=%o", k, ctrl1, exp_c[k]);
            end
            if (busy0 !== 1'b0 || ctrl0 !== '0) begin
                failures++;
                $display("FAIL illegal_granted cyc=%0d busy=%b ctrl=%o exp busy=0 ctrl=0", k, busy0, ctrl0);
            end
            step(1);
        end
        checks += 1;
        if (src0 !== 3'd6) begin failures++; $display("FAIL illegal_src_kept got=%0d exp=6", src0); end
        req0 = '0;
        step(1);
        checks += 1;
        if (ill0 !== 8'h00) begin failures++; $display("FAIL illegal_clear got=%b exp=0", ill0); end
    endtask

    task automatic test_reset_mid();
        req0[0*RO +: RO] = {1'b1, 3'd7};
        step(1);
        req0 = '0;
        checks += 1;
        if (ctrl0 !== 24'o00000004) begin failures++; $display("FAIL mid_tx got=%o exp=00000004", ctrl0); end
        for (int k = 1; k <= 3; k++) begin
            step(1);
            checks += 1;
            if (ctrl0 !== 24'o01111110) begin
                failures++;
                $display("FAIL mid_hop cyc=%0d got=%o exp=01111110", k, ctrl0);
            end
        end
        reset = 1'b0;
        step(1);
        checks += 4;
        if (ctrl0 !== '0) begin failures++; $display("FAIL mid_rst_ctrl got=%o exp=0", ctrl0); end
        if (busy0 !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy0); end
        if (src0 !== 3'd0) begin failures++; $display("FAIL mid_rst_src got=%0d exp=0", src0); end
        if (dst0 !== 3'd0) begin failures++; $display("FAIL mid_rst_dst got=%0d exp=0", dst0); end
        // Node 3 competes: only a cleared rr_ptr picks node 0 first.
        req0[0*RO +: RO] = {1'b1, 3'd7};
        req0[3*RO +: RO] = {1'b1, 3'd5};
        reset = 1'b1;
        step(1);
        req0 = '0;
        checks += 2;
        if (src0 !== 3'd0) begin failures++; $display("FAIL mid_regrant_src got=%0d exp=0", src0); end
        if (ctrl0 !== 24'o00000004) begin failures++; $display("FAIL mid_regrant_tx got=%o exp=00000004", ctrl0); end
        step(8);
        checks += 1;
        if (busy0 !== 1'b0) begin failures++; $display("FAIL mid_done_busy got=%b exp=0", busy0); end
    endtask

    task automatic test_back_to_back();
        int unsigned exp_src [4];
        int  grants = 0;
        int  gap    = 0;
        logic prev  = 1'b0;
        exp_src = '{1, 4, 1, 4};
        reset = 1'b0;
        req0 = '0;
        req0[1*RO +: RO] = {1'b1, 3'd7};
        req0[4*RO +: RO] = {1'b1, 3'd6};
        step(2);
        reset = 1'b1;
        for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
            step(1);
            if (busy0 && !prev) begin
                checks += 1;
                if (32'(src0) != exp_src[grants]) begin
                    failures++;
                    $display("FAIL rr_order grant=%0d got=%0d exp=%0d", grants, src0, exp_src[grants]);
                end
                if (grants > 0) begin
                    checks += 1;
                    if (gap != 1) begin
                        failures++;
                        $display("FAIL rr_gap grant=%0d got=%0d exp=1", grants, gap);
                    end
                end
                grants++;
                gap = 0;
            end else if (!busy0) begin
                gap++;
            end
            prev = busy0;
        end
        checks += 1;
        if (grants != 4) begin failures++; $display("FAIL rr_timeout got=%0d grants exp=4", grants); end
        req0 = '0;
        step(10);
    endtask

`ifdef SEGMENT_ARBITER_STATS_EN
    task automatic test_stats();
        reset = 1'b0;
        req0 = '0;
        step(2);
        reset = 1'b1;
        checks += 2;
        if (xc0 !== 16'd0) begin failures++; $display("FAIL stats_rst_xfer got=%0d exp=0", xc0); end
        if (ic0 !== 16'd0) begin failures++; $display("FAIL stats_rst_ill got=%0d exp=0", ic0); end
        for (int t = 0; t < 3; t++) begin
            req0[6*RO +: RO] = {1'b1, 3'd7};
            step(1);
            req0 = '0;
            step(2);
        end
        req0[5*RO +: RO] = {1'b1, 3'd3};
        step(2);
        req0 = '0;
        step(1);
        checks += 2;
        if (xc0 !== 16'd3) begin failures++; $display("FAIL stats_xfer got=%0d exp=3", xc0); end
        if (ic0 !== 16'd2) begin failures++; $display("FAIL stats_ill got=%0d exp=2", ic0); end
        req0[5*RO +: RO] = {1'b1, 3'd3};
        step(65540);
        checks += 1;
        if (ic0 !== 16'hFFFF) begin failures++; $display("FAIL stats_sat got=%h exp=ffff", ic0); end
        step(3);
        checks += 1;
        if (ic0 !== 16'hFFFF) begin failures++; $display("FAIL stats_sat_hold got=%h exp=ffff", ic0); end
        req0 = '0;
        step(2);
    endtask
`endif

    initial begin
        test_reset();
        test_hop_2_to_5();
        test_short_6_to_7();
        test_illegal_and_dir1();
        test_reset_mid();
        test_back_to_back();
`ifdef SEGMENT_ARBITER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
